// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: pops one byte per transfer, pulses run, waits for done.
// Optional stuck-transmitter watchdog enabled by defining UART_TXQ_TIMEOUT_EN.
module uart_tx_queue #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic [7:0]    din,
  output logic          run,
  input  logic          done,
  output logic          busy,
  output logic [15:0]   tx_count,
  output logic          tmo
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        ovf_q, done_q, run_q;
  logic [7:0]  din_q;
  logic [15:0] tx_count_q;
  state_t      state_q;
  logic        push, done_rise;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign push      = wr_en && !full;
  assign done_rise = done && !done_q;

  assign ovf      = ovf_q;
  assign din      = din_q;
  assign run      = run_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_count = tx_count_q;

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Drop decision uses full from before the edge; a dropped push beats clr_ovf.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (wr_en && full) ovf_q <= 1'b1;
      else if (clr_ovf)  ovf_q <= 1'b0;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
  logic [TW-1:0] tcnt_q;
  logic          tmo_q;
  assign tmo = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      din_q      <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      tx_count_q <= '0;
`ifdef UART_TXQ_TIMEOUT_EN
      tcnt_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      done_q <= done;
      run_q  <= 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            din_q    <= mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            run_q    <= 1'b1;
            state_q  <= S_WAIT;
`ifdef UART_TXQ_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (done_rise) begin
            tx_count_q <= tx_count_q + 16'd1;
            state_q    <= S_IDLE;
          end
`ifdef UART_TXQ_TIMEOUT_EN
          // Completion on the final count still wins over the abort.
          else if (tcnt_q == TCNT_LAST) begin
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_ONE;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: scoreboard on popped bytes plus a vector table for fill/overflow.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 32;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        wr_en, clr_ovf, done;
  logic [7:0]  wr_data;
  logic        full, empty, ovf, run, busy, tmo;
  logic [AW:0] count;
  logic [7:0]  din;
  logic [15:0] tx_count;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count), .ovf(ovf),
    .din(din), .run(run), .done(done), .busy(busy), .tx_count(tx_count), .tmo(tmo)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbq[$];
  int   mcount = 0;
  logic prev_run = 1'b0;
  logic run_seen = 1'b0;
  int   exp_tx = 0;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       c;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       run;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic c, input logic dn);
    logic [7:0] e;
    wr_en = w; wr_data = d; clr_ovf = c; done = dn;
    if (w && mcount < DEPTH) begin
      sbq.push_back(d);
      mcount++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    if (run) begin
      chk("run_width", {31'd0, prev_run}, 32'd0);
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("din_order", {24'd0, din}, {24'd0, e});
      end
      mcount--;
      run_seen = 1'b1;
    end
    prev_run = run;
  endtask

  task automatic wait_run(input int budget, output int n);
    n = 0;
    while (!run_seen && n < budget) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    chk("run_seen", {31'd0, run_seen}, 32'd1);
    run_seen = 1'b0;
  endtask

  task automatic flush_model();
    sbq.delete();
    mcount   = 0;
    prev_run = 1'b0;
    run_seen = 1'b0;
    exp_tx   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; done = 1'b0;
    #3;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    chk("rst_din",   {24'd0, din},   32'd0);
    chk("rst_run",   {31'd0, run},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_txc",   {16'd0, tx_count}, 32'd0);
    chk("rst_tmo",   {31'd0, tmo},   32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Single byte into an idle queue.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_count", {27'd0, count}, 32'd1);
    chk("a5_norun", {31'd0, run}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_run",  {31'd0, run},  32'd1);
    chk("a5_busy", {31'd0, busy}, 32'd1);
    run_seen = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_run_low", {31'd0, run}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("a5_txc",   {16'd0, tx_count}, exp_tx);
    chk("a5_idle",  {31'd0, busy},  32'd0);
    chk("a5_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Three back-to-back bytes, done answered a few cycles after each run.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_run(10, n);
      if (i > 0) chk("b2b_gap", n, 32'd1);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      exp_tx++;
      chk("b2b_idle", {31'd0, busy}, 32'd0);
    end
    chk("b2b_txc", {16'd0, tx_count}, exp_tx);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Level done: counted once, next run one cycle after the rise.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h6B, 1'b0, 1'b0);
    wait_run(10, n);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("lvl_txc1", {16'd0, tx_count}, exp_tx);
    chk("lvl_idle", {31'd0, busy}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("lvl_next_run", {31'd0, run}, 32'd1);
    run_seen = 1'b0;
    for (int k = 0; k < 18; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("lvl_txc_hold", {16'd0, tx_count}, exp_tx);
    chk("lvl_busy",     {31'd0, busy}, 32'd1);
    chk("lvl_tmo",      {31'd0, tmo},  32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("lvl_txc2", {16'd0, tx_count}, exp_tx);
    chk("lvl_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill/overflow vectors with done held low.
    for (int k = 1; k <= 17; k++) begin
      tbl[k-1] = '{w: 1'b1, d: 8'(k-1), c: 1'b0,
                   cnt: (k == 1) ? 5'd1 : 5'(k-1),
                   full: (k == 17), empty: 1'b0, ovf: 1'b0,
                   busy: (k >= 2), run: (k == 2)};
    end
    tbl[17] = '{w: 1'b1, d: 8'h11, c: 1'b0, cnt: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1, busy: 1'b1, run: 1'b0};
    tbl[18] = '{w: 1'b1, d: 8'h12, c: 1'b1, cnt: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1, busy: 1'b1, run: 1'b0};
    tbl[19] = '{w: 1'b0, d: 8'h00, c: 1'b1, cnt: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0, busy: 1'b1, run: 1'b0};
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].c, 1'b0);
      chk("tbl_count", {27'd0, count}, {27'd0, tbl[i].cnt});
      chk("tbl_full",  {31'd0, full},  {31'd0, tbl[i].full});
      chk("tbl_empty", {31'd0, empty}, {31'd0, tbl[i].empty});
      chk("tbl_ovf",   {31'd0, ovf},   {31'd0, tbl[i].ovf});
      chk("tbl_busy",  {31'd0, busy},  {31'd0, tbl[i].busy});
      chk("tbl_run",   {31'd0, run},   {31'd0, tbl[i].run});
    end
    run_seen = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("ovf_txc", {16'd0, tx_count}, exp_tx);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_next_run", {31'd0, run}, 32'd1);
    run_seen = 1'b0;

    // Asynchronous reset mid-WAIT with bytes queued.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run",   {31'd0, run},   32'd0);
    chk("arst_din",   {24'd0, din},   32'd0);
    chk("arst_count", {27'd0, count}, 32'd0);
    chk("arst_busy",  {31'd0, busy},  32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    flush_model();
    @(negedge clk_in);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("arst_done_ign", {16'd0, tx_count}, 32'd0);
    chk("arst_idle",     {31'd0, busy}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Unanswered transfer.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b0);
    wait_run(5, n);
`ifdef UART_TXQ_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4 * TMO) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
      seen = tmo;
    end
    chk("tmo_seen",  {31'd0, seen}, 32'd1);
    chk("tmo_delay", n, TMO);
    chk("tmo_idle",  {31'd0, busy}, 32'd0);
    chk("tmo_txc",   {16'd0, tx_count}, exp_tx);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_pulse", {31'd0, tmo}, 32'd0);
    chk("tmo_next_run", {31'd0, run}, 32'd1);
    run_seen = 1'b0;
`else
    seen = 1'b0;
    for (int k = 0; k < 2 * TMO; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (tmo) seen = 1'b1;
    end
    chk("notmo_seen", {31'd0, seen}, 32'd0);
    chk("notmo_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("notmo_txc", {16'd0, tx_count}, exp_tx);
    wait_run(5, n);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_tx++;
    chk("end_txc",   {16'd0, tx_count}, exp_tx);
    chk("end_empty", {31'd0, empty}, 32'd1);
    chk("end_sb",    sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
